// File: rtl/hmmm_io_fifo_pkg.sv
// rtl/hmmm_io_fifo_pkg.sv - shared word width and default depth for the Hmmm buffered I/O port
package hmmm_io_fifo_pkg;

  localparam int HMMM_WORD_WIDTH = 16;
  localparam int HMMM_IO_DEPTH   = 4;

endpackage

// File: rtl/hmmm_sync_fifo.sv
// rtl/hmmm_sync_fifo.sv - synchronous show-ahead FIFO with count-derived flags and sync flush
module hmmm_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush resets bookkeeping only; stale words stay in storage.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/hmmm_io_fifo.sv
// rtl/hmmm_io_fifo.sv - buffered Hmmm I/O port: input/output FIFOs, ext handshakes, atomic core stall
module hmmm_io_fifo
  import hmmm_io_fifo_pkg::*;
#(
  parameter int WIDTH     = HMMM_WORD_WIDTH,
  parameter int IN_DEPTH  = HMMM_IO_DEPTH,
  parameter int OUT_DEPTH = HMMM_IO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           cpu_read,
  output logic [WIDTH-1:0]               cpu_rd_data,
  input  logic                           cpu_write,
  input  logic [WIDTH-1:0]               cpu_wr_data,
  output logic                           stall,
  input  logic [WIDTH-1:0]               ext_in_data,
  input  logic                           ext_in_valid,
  output logic                           ext_in_ready,
  output logic [WIDTH-1:0]               ext_out_data,
  output logic                           ext_out_valid,
  input  logic                           ext_out_ready,
  output logic [$clog2(IN_DEPTH+1)-1:0]  in_count,
  output logic [$clog2(OUT_DEPTH+1)-1:0] out_count
);

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;

  // Stall sees only core strobes and registered flags, never ext_* inputs.
  assign stall = (cpu_read && in_empty) || (cpu_write && out_full);

  assign ext_in_ready  = !in_full;
  assign ext_out_valid = !out_empty;

  assign in_push  = ext_in_valid && ext_in_ready;
  assign in_pop   = cpu_read && !stall;
  assign out_push = cpu_write && !stall;
  assign out_pop  = ext_out_valid && ext_out_ready;

  hmmm_sync_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst),
    .flush (flush),
    .push  (in_push),
    .pop   (in_pop),
    .din   (ext_in_data),
    .dout  (cpu_rd_data),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  hmmm_sync_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst),
    .flush (flush),
    .push  (out_push),
    .pop   (out_pop),
    .din   (cpu_wr_data),
    .dout  (ext_out_data),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

endmodule
